// File: rtl/adder_n_pkg.sv
// Shared definitions for the adder_n slice.
//   ADDER_DEFAULT_N : default operand width
//   ref_add         : golden arithmetic model, {cout,sum} = a + b + cin for
//                     operands up to 32 bits (result is 33 bits wide)
package adder_pkg;

    localparam int ADDER_DEFAULT_N = 4;

    function automatic logic [32:0] ref_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic        cin);
        return {1'b0, a} + {1'b0, b} + {32'd0, cin};
    endfunction

endpackage

// File: rtl/adder_n_if.sv
// Operand/result bundle for adder_n.
//   a, b : operands (N bits, unsigned)
//   cin  : carry-in
//   sum  : registered sum (N bits)
//   cout : registered carry-out
// master drives operands and reads results; slave is the adder side.
interface adder_n_if #(
    parameter int N = 4
);
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic [N-1:0] sum;
    logic         cout;

    modport master (output a, b, cin, input sum, cout);
    modport slave  (input a, b, cin, output sum, cout);
endinterface

// File: rtl/adder_n_full_adder.sv
// One-bit full adder, purely combinational.
//   a_i, b_i : operand bits
//   ci_i     : carry in
//   s_o      : sum bit
//   co_o     : carry out
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);
    logic p;

    assign p    = a_i ^ b_i;
    assign s_o  = p ^ ci_i;
    assign co_o = (a_i & b_i) | (ci_i & p);
endmodule

// File: rtl/adder_n.sv
// N-bit ripple-carry adder with registered outputs.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset, clears sum and cout
//   bus : adder_n_if slave; a/b/cin in, {cout,sum} out one cycle later
// Inputs are not registered; only the N+1 result flops hold state.
module adder_n
    import adder_pkg::*;
#(
    parameter int N = ADDER_DEFAULT_N
) (
    input  logic       clk,
    input  logic       rst,
    adder_n_if.slave   bus
);
    logic [N:0]   c;
    logic [N-1:0] sum_d;
    logic         cout_d;
    logic [N-1:0] sum_q;
    logic         cout_q;

    assign c[0] = bus.cin;

    for (genvar i = 0; i < N; i++) begin : g_bit
        full_adder u_fa (
            .a_i  (bus.a[i]),
            .b_i  (bus.b[i]),
            .ci_i (c[i]),
            .s_o  (sum_d[i]),
            .co_o (c[i+1])
        );
    end

    assign cout_d = c[N];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_adder_n.sv
// Directed bench for adder_n: reset behaviour, basic and boundary vectors,
// exhaustive N=4 and N=1, a two-slice 8-bit cascade, and an N=16 sweep.
module tb_adder_n;
    import adder_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    adder_n_if #(.N(4))  if4 ();
    adder_n_if #(.N(4))  iflo ();
    adder_n_if #(.N(4))  ifhi ();
    adder_n_if #(.N(1))  if1 ();
    adder_n_if #(.N(16)) if16 ();

    // Upper slice carry-in comes straight from the lower slice's registered cout.
    assign ifhi.cin = iflo.cout;

    adder_n #(.N(4))  u_a4  (.clk(clk), .rst(rst), .bus(if4));
    adder_n #(.N(4))  u_lo  (.clk(clk), .rst(rst), .bus(iflo));
    adder_n #(.N(4))  u_hi  (.clk(clk), .rst(rst), .bus(ifhi));
    adder_n #(.N(1))  u_a1  (.clk(clk), .rst(rst), .bus(if1));
    adder_n #(.N(16)) u_a16 (.clk(clk), .rst(rst), .bus(if16));

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive4(input int a, input int b, input int cin);
        if4.a   = 4'(a);
        if4.b   = 4'(b);
        if4.cin = 1'(cin);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [32:0] out4();
        return {28'd0, if4.cout, if4.sum};
    endfunction

    initial begin
        logic [8:0]  exp9;
        logic [3:0]  hi_a_d;
        logic [3:0]  hi_b_d;
        logic [3:0]  lo_sum_prev;
        logic [8:0]  exp_prev;
        logic        have_prev;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;

        drive4(0, 0, 0);
        iflo.a = '0; iflo.b = '0; iflo.cin = 1'b0;
        ifhi.a = '0; ifhi.b = '0;
        if1.a = '0;  if1.b = '0;  if1.cin = 1'b0;
        if16.a = '0; if16.b = '0; if16.cin = 1'b0;

        // Reset held with toggling inputs: outputs stay zero.
        for (int k = 0; k < 4; k++) begin
            drive4(int'($urandom_range(15)), int'($urandom_range(15)), int'($urandom_range(1)));
            if1.a = 1'b1; if1.b = 1'b1; if1.cin = 1'b1;
            if16.a = 16'hFFFF; if16.b = 16'hFFFF; if16.cin = 1'b1;
            tick();
            chk("reset_hold4", out4(), 33'd0);
            chk("reset_hold16", {16'd0, if16.cout, if16.sum}, 33'd0);
        end
        #2 rst = 1'b0;

        // First edge after release samples normally.
        drive4(3, 5, 0);
        tick();
        chk("basic_3p5", out4(), 33'h08);

        drive4(7, 9, 0);
        tick();
        chk("basic_7p9", out4(), 33'h10);

        drive4(15, 15, 1);
        tick();
        chk("max_15p15p1", out4(), 33'h1F);

        drive4(15, 0, 1);
        tick();
        chk("max_15p0p1", out4(), 33'h10);

        drive4(15, 1, 0);
        tick();
        chk("wrap_15p1", out4(), 33'h10);

        drive4(0, 0, 0);
        tick();
        chk("zero", out4(), 33'h00);

        // Mid-cycle asynchronous reset.
        drive4(6, 7, 1);
        tick();
        chk("pre_async", out4(), 33'h0E);
        #1 rst = 1'b1;
        #1;
        chk("async_clear", out4(), 33'h00);
        #1 rst = 1'b0;
        tick();
        chk("post_async", out4(), 33'h0E);

        // Exhaustive N=4 and N=1.
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++) begin
                    drive4(a, b, c);
                    if1.a = 1'(a); if1.b = 1'(b); if1.cin = 1'(c);
                    tick();
                    chk("exh4", out4(), ref_add(32'(a), 32'(b), 1'(c)));
                    if (a < 2 && b < 2)
                        chk("exh1", {31'd0, if1.cout, if1.sum},
                            ref_add(32'(a), 32'(b), 1'(c)));
                end

        // Two-slice cascade: upper operands delayed one cycle, lower sum realigned.
        have_prev = 1'b0;
        hi_a_d = '0; hi_b_d = '0;
        lo_sum_prev = '0; exp_prev = '0;
        for (int i = 0; i < 256; i++)
            for (int j = i; j < 256; j++) begin
                iflo.a = 4'(i); iflo.b = 4'(j); iflo.cin = 1'b0;
                ifhi.a = hi_a_d; ifhi.b = hi_b_d;
                tick();
                if (have_prev)
                    chk("cascade", {24'd0, ifhi.cout, ifhi.sum, lo_sum_prev}, {24'd0, exp_prev});
                lo_sum_prev = iflo.sum;
                hi_a_d = 4'(i >> 4);
                hi_b_d = 4'(j >> 4);
                exp9 = 9'(i + j);
                exp_prev = exp9;
                have_prev = 1'b1;
            end
        ifhi.a = hi_a_d; ifhi.b = hi_b_d;
        tick();
        chk("cascade_last", {24'd0, ifhi.cout, ifhi.sum, lo_sum_prev}, {24'd0, exp_prev});

        // N=16 directed corners then random sweep.
        if16.a = 16'hFFFF; if16.b = 16'h0001; if16.cin = 1'b0;
        tick();
        chk("w16_wrap", {16'd0, if16.cout, if16.sum}, 33'h10000);
        if16.a = 16'hFFFF; if16.b = 16'hFFFF; if16.cin = 1'b1;
        tick();
        chk("w16_max", {16'd0, if16.cout, if16.sum}, 33'h1FFFF);
        if16.a = 16'h1234; if16.b = 16'h4321; if16.cin = 1'b1;
        tick();
        chk("w16_mid", {16'd0, if16.cout, if16.sum}, 33'h05556);
        for (int k = 0; k < 64; k++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            if16.a = ra; if16.b = rb; if16.cin = rc;
            tick();
            chk("w16_rand", {16'd0, if16.cout, if16.sum}, ref_add({16'd0, ra}, {16'd0, rb}, rc));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
